// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller: RAW stalls from a 3-entry in-flight scoreboard
// (EXE/MEM/WB), wrong-path squash on taken branches, and drain-to-halt.
module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_LEN = 5,
    parameter bit R0_EXEMPT    = 1'b1,
    parameter int CNT_W        = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    id_valid,
    input  logic [REG_ADDR_LEN-1:0] id_src1,
    input  logic                    id_src1_used,
    input  logic [REG_ADDR_LEN-1:0] id_src2,
    input  logic                    id_src2_used,
    input  logic [REG_ADDR_LEN-1:0] id_dst,
    input  logic                    id_wr,
    input  logic                    id_halt,
    input  logic                    ex_branch_taken,
    output logic                    stall,
    output logic                    bubble,
    output logic                    flush,
    output logic                    halted,
    output logic [CNT_W-1:0]        stall_count
);
    typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, HALTED = 2'd2} state_t;
    typedef struct packed {
        logic                    wr;
        logic [REG_ADDR_LEN-1:0] dst;
        logic                    halt;
    } entry_t;

    state_t           state_q, state_d;
    entry_t           e0_q, e0_d, e1_q, e2_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stall_s, bubble_s, flush_s, halted_s, hz_s;

    // No write-through in the register file, so a WB-stage write still blocks an ID read.
    function automatic logic match(input logic [REG_ADDR_LEN-1:0] r,
                                   input entry_t a, input entry_t b, input entry_t c);
        logic hit;
        hit = (a.wr && (a.dst == r)) || (b.wr && (b.dst == r)) || (c.wr && (c.dst == r));
        return (R0_EXEMPT && (r == {REG_ADDR_LEN{1'b0}})) ? 1'b0 : hit;
    endfunction

    assign hz_s = id_valid && ((id_src1_used && match(id_src1, e0_q, e1_q, e2_q)) ||
                               (id_src2_used && match(id_src2, e0_q, e1_q, e2_q)));

    // Next-state, scoreboard insert and pipeline control decode.
    always_comb begin
        state_d  = state_q;
        e0_d     = '0;
        cnt_d    = cnt_q;
        stall_s  = 1'b0;
        bubble_s = 1'b0;
        flush_s  = 1'b0;
        halted_s = 1'b0;
        case (state_q)
            RUN: begin
                if (ex_branch_taken) begin
                    flush_s  = 1'b1;
                    bubble_s = 1'b1;
                end else if (hz_s) begin
                    stall_s  = 1'b1;
                    bubble_s = 1'b1;
                    if (cnt_q != {CNT_W{1'b1}}) begin
                        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        cnt_d = cnt_q;
                    end
                end else if (id_valid && id_halt) begin
                    e0_d.halt = 1'b1;
                    stall_s   = 1'b1;
                    state_d   = DRAIN;
                end else if (id_valid) begin
                    e0_d.wr  = id_wr;
                    e0_d.dst = id_dst;
                end else begin
                    e0_d = '0;
                end
            end
            DRAIN: begin
                stall_s  = 1'b1;
                bubble_s = 1'b1;
                flush_s  = 1'b1;
                if (e2_q.halt) begin
                    state_d = HALTED;
                end else begin
                    state_d = DRAIN;
                end
            end
            HALTED: begin
                stall_s  = 1'b1;
                bubble_s = 1'b1;
                flush_s  = 1'b1;
                halted_s = 1'b1;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // State, scoreboard shift and stall statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            e0_q    <= '0;
            e1_q    <= '0;
            e2_q    <= '0;
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            e0_q    <= e0_d;
            e1_q    <= e0_q;
            e2_q    <= e1_q;
            cnt_q   <= cnt_d;
        end
    end

    assign stall       = rst_n & stall_s;
    assign bubble      = rst_n & bubble_s;
    assign flush       = rst_n & flush_s;
    assign halted      = rst_n & halted_s;
    assign stall_count = cnt_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench: two instances (R0 exempt / not exempt) against a cycle-age model.
module tb_pipeline_hazard_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       id_valid = 1'b0, id_src1_used = 1'b0, id_src2_used = 1'b0;
    logic       id_wr = 1'b0, id_halt = 1'b0, ex_branch_taken = 1'b0;
    logic [4:0] id_src1 = 5'd0, id_src2 = 5'd0, id_dst = 5'd0;
    logic       stall1, bubble1, flush1, halted1, stall0, bubble0, flush0, halted0;
    logic [15:0] cnt1, cnt0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.REG_ADDR_LEN(5), .R0_EXEMPT(1'b1), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src1(id_src1),
        .id_src1_used(id_src1_used), .id_src2(id_src2), .id_src2_used(id_src2_used),
        .id_dst(id_dst), .id_wr(id_wr), .id_halt(id_halt), .ex_branch_taken(ex_branch_taken),
        .stall(stall1), .bubble(bubble1), .flush(flush1), .halted(halted1), .stall_count(cnt1));

    pipeline_hazard_ctrl #(.REG_ADDR_LEN(5), .R0_EXEMPT(1'b0), .CNT_W(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src1(id_src1),
        .id_src1_used(id_src1_used), .id_src2(id_src2), .id_src2_used(id_src2_used),
        .id_dst(id_dst), .id_wr(id_wr), .id_halt(id_halt), .ex_branch_taken(ex_branch_taken),
        .stall(stall0), .bubble(bubble0), .flush(flush0), .halted(halted0), .stall_count(cnt0));

    typedef struct {
        logic       v;
        logic [4:0] s1;
        logic       s1u;
        logic [4:0] s2;
        logic       s2u;
        logic [4:0] dst;
        logic       wr, halt, br;
        logic [3:0] e_out;   // {stall, bubble, flush, halted} of the exempt instance
        int         e_cnt;   // -1: not checked
        logic       e_stall0;
    } vec_t;

    int n_chk = 0, n_pass = 0;
    int cyc = 0;
    int last_wr [2][32];
    int halt_cyc [2];
    int cnt [2];
    bit exempt [2] = '{1'b0, 1'b1};   // index 0 -> dut0, index 1 -> dut

    function automatic vec_t mk(input logic v, input logic [4:0] s1, input logic s1u,
                                input logic [4:0] s2, input logic s2u, input logic [4:0] dst,
                                input logic wr, input logic halt, input logic br,
                                input logic [3:0] e_out, input int e_cnt, input logic e_stall0);
        vec_t r;
        r.v = v; r.s1 = s1; r.s1u = s1u; r.s2 = s2; r.s2u = s2u; r.dst = dst;
        r.wr = wr; r.halt = halt; r.br = br; r.e_out = e_out; r.e_cnt = e_cnt;
        r.e_stall0 = e_stall0;
        return r;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s @cyc %0d: got %0d expected %0d", nm, cyc, act, exp);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < 32; r++) last_wr[k][r] = -1000;
            halt_cyc[k] = -1;
            cnt[k] = 0;
        end
    endtask

    // A register is busy while its writer issued within the last three cycles.
    function automatic bit busy(input int k, input logic [4:0] r);
        if (exempt[k] && r == 5'd0) return 1'b0;
        return (cyc - last_wr[k][r]) <= 3;
    endfunction

    task automatic model(input int k, input vec_t v, output logic [3:0] e);
        bit hz;
        if (halt_cyc[k] >= 0 && cyc > halt_cyc[k]) begin
            e = ((cyc - halt_cyc[k]) >= 4) ? 4'b1111 : 4'b1110;
        end else begin
            hz = v.v && ((v.s1u && busy(k, v.s1)) || (v.s2u && busy(k, v.s2)));
            if (v.br) e = 4'b0110;
            else if (hz) begin
                e = 4'b1100;
                if (cnt[k] < 65535) cnt[k]++;
            end else if (v.v && v.halt) begin
                e = 4'b1000;
                halt_cyc[k] = cyc;
            end else begin
                e = 4'b0000;
                if (v.v && v.wr) last_wr[k][v.dst] = cyc;
            end
        end
    endtask

    task automatic drive(input vec_t v);
        id_valid = v.v; id_src1 = v.s1; id_src1_used = v.s1u; id_src2 = v.s2;
        id_src2_used = v.s2u; id_dst = v.dst; id_wr = v.wr; id_halt = v.halt;
        ex_branch_taken = v.br;
    endtask

    task automatic step(input vec_t v, input bit tbl);
        logic [3:0] a [2];
        int         ac [2];
        logic [3:0] e;
        int         ec;
        drive(v);
        @(negedge clk);
        a[1] = {stall1, bubble1, flush1, halted1}; ac[1] = int'(cnt1);
        a[0] = {stall0, bubble0, flush0, halted0}; ac[0] = int'(cnt0);
        if (tbl) begin
            chk("tbl_ctrl", int'(a[1]), int'(v.e_out));
            chk("tbl_stall_r0", int'(stall0), int'(v.e_stall0));
            if (v.e_cnt >= 0) chk("tbl_count", ac[1], v.e_cnt);
        end
        for (int k = 0; k < 2; k++) begin
            ec = cnt[k];
            model(k, v, e);
            chk($sformatf("stall%0d", k),  int'(a[k][3]), int'(e[3]));
            chk($sformatf("bubble%0d", k), int'(a[k][2]), int'(e[2]));
            chk($sformatf("flush%0d", k),  int'(a[k][1]), int'(e[1]));
            chk($sformatf("halted%0d", k), int'(a[k][0]), int'(e[0]));
            chk($sformatf("count%0d", k),  ac[k], ec);
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset pulse in the middle of a cycle.
    task automatic rst_mid();
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, -1, 0));
        #2 rst_n = 1'b0;
        #1;
        chk("rst_ctrl1", int'({stall1, bubble1, flush1, halted1}), 0);
        chk("rst_ctrl0", int'({stall0, bubble0, flush0, halted0}), 0);
        chk("rst_cnt1", int'(cnt1), 0);
        chk("rst_cnt0", int'(cnt0), 0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    vec_t tbl [14];
    vec_t rv;

    initial begin
        tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0);
        tbl[1]  = mk(1, 0, 0, 0, 0, 3, 1, 0, 0, 4'b0000, 0, 0);   // ADD r3
        tbl[2]  = mk(1, 3, 1, 0, 0, 0, 0, 0, 0, 4'b1100, 0, 1);   // read r3
        tbl[3]  = mk(1, 3, 1, 0, 0, 0, 0, 0, 0, 4'b1100, 1, 1);
        tbl[4]  = mk(1, 3, 1, 0, 0, 0, 0, 0, 0, 4'b1100, 2, 1);
        tbl[5]  = mk(1, 3, 1, 0, 0, 0, 0, 0, 0, 4'b0000, 3, 0);
        tbl[6]  = mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 4'b0000, 3, 0);   // write r0
        tbl[7]  = mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 4'b0000, 3, 1);   // read r0
        tbl[8]  = mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 4'b0000, 3, 1);
        tbl[9]  = mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 4'b0000, 3, 1);
        tbl[10] = mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 4'b0000, 3, 0);
        tbl[11] = mk(1, 0, 0, 0, 0, 5, 1, 0, 0, 4'b0000, 3, 0);   // write r5
        tbl[12] = mk(1, 0, 0, 5, 1, 6, 1, 0, 1, 4'b0110, 3, 0);   // hazard on r5, branch
        tbl[13] = mk(1, 6, 1, 0, 0, 0, 0, 0, 0, 4'b0000, 3, 0);   // squashed r6 never issued

        model_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("init_ctrl1", int'({stall1, bubble1, flush1, halted1}), 0);
        chk("init_cnt1", int'(cnt1), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 14; i++) step(tbl[i], 1'b1);

        // Reset during drain while r7 sits in MEM; r7 must be free afterwards.
        step(mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 4'b0000, 3, 0), 1'b1);
        step(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 4'b1000, 3, 1), 1'b1);
        rst_mid();
        step(mk(1, 7, 1, 7, 1, 0, 0, 0, 0, 4'b0000, 0, 0), 1'b1);

        // Halt latency: stall on decode, drain three cycles, then halted and held.
        step(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 4'b1000, 0, 1), 1'b1);
        for (int i = 1; i <= 6; i++) begin
            rv = mk(1'($urandom), 5'($urandom), 1'b1, 5'($urandom), 1'b1, 5'($urandom),
                    1'($urandom), 1'($urandom), 1'($urandom),
                    (i >= 4) ? 4'b1111 : 4'b1110, 0, 1);
            step(rv, 1'b1);
        end

        for (int n = 0; n < 400; n++) begin
            if (n % 80 == 0) rst_mid();
            rv = mk(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)), 1'($urandom),
                    5'($urandom_range(0, 3)), 1'($urandom), 5'($urandom_range(0, 3)),
                    1'($urandom), ($urandom_range(0, 49) == 0), ($urandom_range(0, 7) == 0),
                    4'b0000, -1, 0);
            step(rv, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
